// File: rtl/gpu_fb_pkg.sv
// Shared constants and FSM encodings for the GPU framebuffer writer.
// Default geometry matches a 320x240 8-bit double-buffered display.
package gpu_fb_pkg;

  localparam int FB_W      = 320;
  localparam int FB_H      = 240;
  localparam int BUF_WORDS = FB_W * FB_H;
  localparam int COLOR_W   = 8;
  localparam int COORD_W   = 11;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

endpackage

// File: rtl/gpu_fb_writer_addr_gen.sv
// Two-stage pixel pipeline: clip and capture, then multiply-add
// into a linear framebuffer address.
module fb_addr_gen
  import gpu_fb_pkg::*;
#(
  parameter int W  = 320,
  parameter int H  = 240,
  parameter int AW = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid,
  input  logic               draw,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COLOR_W-1:0] color,
  input  logic               buf_idx,
  output logic               wr_en,
  output logic [AW-1:0]      addr,
  output logic [COLOR_W-1:0] data
);

  localparam int MW = COORD_W + $clog2(W);

  logic               s0_v;
  logic               s0_buf;
  logic [COORD_W-1:0] s0_x;
  logic [COORD_W-1:0] s0_y;
  logic [COLOR_W-1:0] s0_c;
  logic [MW-1:0]      prod;
  logic               in_bounds;

  assign in_bounds = (x < COORD_W'(W)) && (y < COORD_W'(H));
  assign prod = MW'(s0_y) * MW'(W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_v   <= 1'b0;
      s0_buf <= 1'b0;
      s0_x   <= '0;
      s0_y   <= '0;
      s0_c   <= '0;
      wr_en  <= 1'b0;
      addr   <= '0;
      data   <= '0;
    end else begin
      s0_v   <= valid && draw && in_bounds;
      s0_buf <= buf_idx;
      s0_x   <= x;
      s0_y   <= y;
      s0_c   <= color;
      wr_en  <= s0_v;
      addr   <= AW'(prod) + AW'(s0_x)
              + (s0_buf ? AW'(W * H) : '0);
      data   <= s0_c;
    end
  end

endmodule

// File: rtl/gpu_fb_writer.sv
// Framebuffer writer: clipped pixel writes into the back buffer,
// buffer swap on frame end, optional clear of the new back buffer.
module gpu_fb_writer #(
  parameter int FB_W   = 320,
  parameter int FB_H   = 240,
  parameter int ADDR_W = 18,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        px_color,
  input  logic              px_valid,
  input  logic [10:0]       px_x,
  input  logic [10:0]       px_y,
  input  logic              px_frame_end,
  input  logic              px_draw,
  input  logic              clear_en,
  input  logic [7:0]        clear_color,
  output logic [ADDR_W-1:0] fb_wr_addr,
  output logic [7:0]        fb_wr_data,
  output logic              fb_wr_en,
  output logic              front_buf,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_count,
  output logic [CNT_W-1:0]  drop_count
);

  import gpu_fb_pkg::*;

  localparam int BUF = FB_W * FB_H;

  logic [1:0]        state;
  logic              drain_cnt;
  logic [ADDR_W-1:0] clr_cnt;
  logic              clr_done;
  logic [ADDR_W-1:0] clr_base;
  logic              pix_ok;
  logic              pipe_en;
  logic [ADDR_W-1:0] pipe_addr;
  logic [7:0]        pipe_data;

  assign busy     = (state != ST_RUN);
  assign pix_ok   = px_valid && !busy;
  assign clr_base = front_buf ? '0 : ADDR_W'(BUF);

  fb_addr_gen #(
    .W  (FB_W),
    .H  (FB_H),
    .AW (ADDR_W)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (reset),
    .valid   (pix_ok),
    .draw    (px_draw),
    .x       (px_x),
    .y       (px_y),
    .color   (px_color),
    .buf_idx (~front_buf),
    .wr_en   (pipe_en),
    .addr    (pipe_addr),
    .data    (pipe_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_RUN;
      drain_cnt   <= 1'b0;
      clr_cnt     <= '0;
      clr_done    <= 1'b0;
      front_buf   <= 1'b0;
      frame_count <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (px_frame_end) begin
            state       <= ST_DRAIN;
            drain_cnt   <= 1'b0;
            frame_count <= frame_count + CNT_W'(1);
          end
        end
        ST_DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) begin
            front_buf <= ~front_buf;
            clr_cnt   <= '0;
            clr_done  <= 1'b0;
            state     <= clear_en ? ST_CLEAR : ST_RUN;
          end
        end
        ST_CLEAR: begin
          // hold CLEAR one extra cycle so busy drops with the last write
          if (clr_done) begin
            state <= ST_RUN;
          end else begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
            if (clr_cnt == ADDR_W'(BUF - 1))
              clr_done <= 1'b1;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
    end else if (busy && px_valid && drop_count != '1) begin
      drop_count <= drop_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fb_wr_en   <= 1'b0;
      fb_wr_addr <= '0;
      fb_wr_data <= '0;
    end else if (state == ST_CLEAR) begin
      fb_wr_en   <= ~clr_done;
      fb_wr_addr <= clr_base + clr_cnt;
      fb_wr_data <= clear_color;
    end else begin
      fb_wr_en   <= pipe_en;
      fb_wr_addr <= pipe_addr;
      fb_wr_data <= pipe_data;
    end
  end

endmodule

// File: tb/tb_gpu_fb_writer.sv
// Bench for gpu_fb_writer: table vectors, directed swap/clear/reset
// sequences and random traffic against a scheduled-write model.
module tb_gpu_fb_writer;

  localparam int W    = 320;
  localparam int H    = 240;
  localparam int BUFW = W * H;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  px_color;
  logic        px_valid;
  logic [10:0] px_x;
  logic [10:0] px_y;
  logic        px_frame_end;
  logic        px_draw;
  logic        clear_en;
  logic [7:0]  clear_color;
  logic [17:0] fb_wr_addr;
  logic [7:0]  fb_wr_data;
  logic        fb_wr_en;
  logic        front_buf;
  logic        busy;
  logic [15:0] frame_count;
  logic [15:0] drop_count;

  always #5 clk = ~clk;

  gpu_fb_writer dut (
    .clk          (clk),
    .reset        (reset),
    .px_color     (px_color),
    .px_valid     (px_valid),
    .px_x         (px_x),
    .px_y         (px_y),
    .px_frame_end (px_frame_end),
    .px_draw      (px_draw),
    .clear_en     (clear_en),
    .clear_color  (clear_color),
    .fb_wr_addr   (fb_wr_addr),
    .fb_wr_data   (fb_wr_data),
    .fb_wr_en     (fb_wr_en),
    .front_buf    (front_buf),
    .busy         (busy),
    .frame_count  (frame_count),
    .drop_count   (drop_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t",
               name, got, exp, $time);
    end
  endtask

  // Model: writes are scheduled by edge index; busy is an edge window.
  int          e;
  int          bs, be, dexit, cs, ce, cbase;
  int          fcnt, dcnt;
  bit          mfront;
  logic [7:0]  mclr;
  logic [25:0] pix [int];

  function automatic void model_reset();
    pix.delete();
    bs = 0; be = 0; dexit = -1;
    cs = 1; ce = 0; cbase = 0;
    fcnt = 0; dcnt = 0; mfront = 0; mclr = 8'h00;
  endfunction

  function automatic void model_edge();
    bit bz;
    int a;
    e++;
    bz = (e - 1 >= bs) && (e - 1 < be);
    if (bz) begin
      if (px_valid && dcnt != 16'hFFFF) dcnt++;
    end else begin
      if (px_valid && px_draw && int'(px_x) < W && int'(px_y) < H) begin
        a = (mfront ? 0 : BUFW) + int'(px_y) * W + int'(px_x);
        pix[e + 2] = {a[17:0], px_color};
      end
      if (px_frame_end) begin
        fcnt++;
        bs = e; be = e + 2; dexit = e + 2;
      end
    end
    if (e == dexit) begin
      mfront = ~mfront;
      if (clear_en) begin
        cs = e + 1; ce = e + BUFW; be = e + 1 + BUFW;
        cbase = mfront ? 0 : BUFW;
        mclr = clear_color;
      end
    end
  endfunction

  task automatic check_all();
    bit ex_en;
    ex_en = pix.exists(e) || (e >= cs && e <= ce);
    chk("wr_en", fb_wr_en, ex_en);
    if (ex_en) begin
      if (pix.exists(e)) begin
        chk("wr_addr", fb_wr_addr, pix[e][25:8]);
        chk("wr_data", fb_wr_data, pix[e][7:0]);
      end else begin
        chk("clr_addr", fb_wr_addr, cbase + (e - cs));
        chk("clr_data", fb_wr_data, mclr);
      end
    end
    if (pix.exists(e)) pix.delete(e);
    chk("busy", busy, (e >= bs) && (e < be));
    chk("front_buf", front_buf, mfront);
    chk("frame_count", frame_count, fcnt & 16'hFFFF);
    chk("drop_count", drop_count, dcnt);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    px_valid = 1'b0;
    px_frame_end = 1'b0;
  endtask

  task automatic pixel(int x, int y, logic [7:0] c, logic d);
    px_valid = 1'b1;
    px_draw  = d;
    px_x     = 11'(x);
    px_y     = 11'(y);
    px_color = c;
  endtask

  typedef struct {
    logic       d;
    int         x;
    int         y;
    logic [7:0] c;
    logic       en;
    int         addr;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int nb, nw, first, last, bad;
    bit prev_en, done;

    tbl[0] = '{1'b1,    5,    2, 8'hAB, 1'b1, 77445};
    tbl[1] = '{1'b1,  320,    0, 8'h12, 1'b0, 0};
    tbl[2] = '{1'b1,    0,  240, 8'h34, 1'b0, 0};
    tbl[3] = '{1'b0,   10,   10, 8'h56, 1'b0, 0};
    tbl[4] = '{1'b1,  319,  239, 8'h5A, 1'b1, 153599};
    tbl[5] = '{1'b1,    0,    0, 8'h01, 1'b1, 76800};
    tbl[6] = '{1'b1, 2047, 2047, 8'hFF, 1'b0, 0};

    reset = 1'b1;
    px_valid = 0; px_draw = 0; px_x = 0; px_y = 0; px_color = 0;
    px_frame_end = 0; clear_en = 0; clear_color = 0;
    e = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_en", fb_wr_en, 0);
    chk("rst_addr", fb_wr_addr, 0);
    chk("rst_data", fb_wr_data, 0);
    chk("rst_front", front_buf, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fc", frame_count, 0);
    chk("rst_dc", drop_count, 0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      pixel(tbl[i].x, tbl[i].y, tbl[i].c, tbl[i].d);
      cyc();
      idle();
      cyc();
      cyc();
      chk($sformatf("vec%0d_en", i), fb_wr_en, tbl[i].en);
      if (tbl[i].en) begin
        chk($sformatf("vec%0d_addr", i), fb_wr_addr, tbl[i].addr);
        chk($sformatf("vec%0d_data", i), fb_wr_data, tbl[i].c);
      end
      cyc();
    end
    chk("vec_drops", drop_count, 0);

    // frame end with a same-cycle pixel, no clear
    pixel(1, 0, 8'h3C, 1'b1);
    px_frame_end = 1'b1;
    cyc();
    idle();
    nb = 0;
    for (int i = 0; i < 10 && busy; i++) begin
      nb++;
      cyc();
    end
    chk("drain_busy_cycles", nb, 2);
    chk("fe_pix_en", fb_wr_en, 1);
    chk("fe_pix_addr", fb_wr_addr, 76801);
    chk("fe_front", front_buf, 1);
    chk("fe_fc", frame_count, 1);
    pixel(0, 0, 8'h77, 1'b1);
    cyc();
    idle();
    cyc();
    cyc();
    chk("swap_pix_en", fb_wr_en, 1);
    chk("swap_pix_addr", fb_wr_addr, 0);
    cyc();

    px_frame_end = 1'b1;
    cyc();
    idle();
    repeat (3) cyc();

    // full clear with drops and an ignored frame_end
    clear_en = 1'b1;
    clear_color = 8'h11;
    px_frame_end = 1'b1;
    cyc();
    idle();
    nw = 0; first = -1; last = -1; bad = 0; prev_en = 0; done = 0;
    for (int i = 0; i < 80000; i++) begin
      if (i == 100 || i == 200 || i == 300) pixel(1, 1, 8'hEE, 1'b1);
      else px_valid = 1'b0;
      px_frame_end = (i == 400);
      prev_en = fb_wr_en;
      cyc();
      if (fb_wr_en) begin
        nw++;
        if (nw == 1) first = int'(fb_wr_addr);
        last = int'(fb_wr_addr);
        if (fb_wr_data !== 8'h11) bad++;
      end
      if (!busy) begin
        done = 1;
        break;
      end
    end
    idle();
    clear_en = 1'b0;
    chk("clear_done", done, 1);
    chk("clear_writes", nw, BUFW);
    chk("clear_first", first, 0);
    chk("clear_last", last, BUFW - 1);
    chk("clear_bad_data", bad, 0);
    chk("clear_tail_en", {prev_en, fb_wr_en}, 2'b10);
    chk("clear_drops", drop_count, 3);
    chk("clear_fc", frame_count, 3);
    chk("clear_front", front_buf, 1);

    // reset in the middle of a clear
    clear_en = 1'b1;
    clear_color = 8'h22;
    px_frame_end = 1'b1;
    cyc();
    idle();
    done = 0;
    for (int i = 0; i < 2000; i++) begin
      if (e == cs + 1000) begin
        done = 1;
        break;
      end
      cyc();
    end
    chk("midclr_reached", done, 1);
    chk("midclr_addr", fb_wr_addr, BUFW + 1000);
    reset = 1'b1;
    #1;
    chk("midrst_en", fb_wr_en, 0);
    chk("midrst_front", front_buf, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_fc", frame_count, 0);
    chk("midrst_dc", drop_count, 0);
    model_reset();
    clear_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    pixel(3, 1, 8'h5E, 1'b1);
    cyc();
    idle();
    cyc();
    chk("postrst_early", fb_wr_en, 0);
    cyc();
    chk("postrst_en", fb_wr_en, 1);
    chk("postrst_addr", fb_wr_addr, BUFW + 323);
    chk("postrst_data", fb_wr_data, 8'h5E);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      px_valid = ($urandom % 4) != 0;
      px_draw  = ($urandom % 8) != 0;
      px_x = ($urandom % 16 == 0) ? 11'h7FF : 11'($urandom_range(0, 340));
      px_y = ($urandom % 16 == 0) ? 11'h7FF : 11'($urandom_range(0, 260));
      px_color = 8'($urandom);
      px_frame_end = ($urandom % 60) == 0;
      cyc();
    end
    idle();
    repeat (4) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
